mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter MEM_LAT, default 2, memory read latency in cycles (legal range 1..15).
REQ-004 SHALL have parameter STARVE_MAX, default 4, the number of consecutive data grants allowed while fetch waits.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-006 SHALL have fetch-port signals: if_req in 1; if_addr in ADDR_W; if_gnt out 1; if_rvalid out 1; if_rdata out DATA_W.
REQ-007 SHALL have data-port signals: dm_req in 1; dm_we in 1; dm_addr in ADDR_W; dm_wdata in DATA_W; dm_gnt out 1; dm_rvalid out 1; dm_rdata out DATA_W.
REQ-008 SHALL have memory-side signals: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W.
REQ-009 SHALL have status output stall_if out 1, high when if_req is high and if_gnt is low.

Function
REQ-010 SHALL share one single-port, non-pipelined memory between fetch and data stages, with at most one access outstanding.
REQ-011 SHALL implement two states: IDLE (a grant is possible) and WAIT (access in flight, down-counter lat_cnt running).
REQ-012 SHALL, in IDLE with any request high, grant in the same cycle: gnt pulses for 1 cycle; mem_en=1; mem_addr, mem_we and mem_wdata are driven from the winner; state moves to WAIT with lat_cnt=MEM_LAT-1.
REQ-013 SHALL give priority to dm_req, except when starve_cnt==STARVE_MAX and if_req=1, in which case fetch wins.
REQ-014 SHALL increment starve_cnt, saturating at STARVE_MAX, on each data grant made while if_req=1; it clears on a fetch grant or whenever if_req=0.
REQ-015 SHALL assert the winner's rvalid exactly MEM_LAT cycles after its grant cycle, with rdata = mem_rdata in that cycle; a write also returns rvalid, with rdata=0.
REQ-016 SHALL permit a new grant in the same cycle as rvalid, giving back-to-back throughput of one access per MEM_LAT cycles.
REQ-017 SHALL keep gnt low in WAIT, except in its final cycle, which is treated as IDLE.
REQ-018 SHALL require requesters to hold req, addr, we and wdata stable until gnt; a req that drops before gnt is ignored.
REQ-019 SHALL drive mem_we low and mem_en low when no grant occurs; the rvalid of the non-winning port stays low.
REQ-020 SHALL hold if_rdata and dm_rdata at 0 whenever the matching rvalid is low.

Reset
REQ-021 SHALL, on reset, set state=IDLE, lat_cnt=0, starve_cnt=0, and drive all outputs to 0.
REQ-022 SHALL, on reset asserted mid-access, abandon the in-flight access: no rvalid is ever produced for it.

Configuration
REQ-023 SHALL, with MEM_ARB_PERF_EN defined, add outputs perf_if_stall and perf_dm_stall (32 bits each), which count cycles with req=1 and gnt=0, wrap at 2^32, and clear on reset.
REQ-024 SHALL, without MEM_ARB_PERF_EN, omit those ports and counters entirely, with functional behaviour otherwise identical.

Structure
REQ-025 SHALL place the state enum (ARB_IDLE, ARB_WAIT) and the default widths and latency constants in shared package mem_arb_pkg.
REQ-026 SHALL contain one sub-module, arb_lat_counter, which loads MEM_LAT-1 on grant, counts down, and flags expiry; all other logic is flat.

Verification
REQ-027 SHALL cover a lone fetch: if_req=1, if_addr=0x100, MEM_LAT=2 -> if_gnt at cycle T; mem_en=1, mem_addr=0x100 at T; if_rvalid at T+2 with if_rdata=mem_rdata.
REQ-028 SHALL cover simultaneous requests: if_req=dm_req=1 in the same cycle, starve_cnt=0 -> dm_gnt first; if_gnt at the rvalid cycle of the data access; stall_if high in between.
REQ-029 SHALL cover starvation: dm_req and if_req held high continuously, STARVE_MAX=4 -> 4 data grants, then 1 fetch grant, then the pattern repeats.
REQ-030 SHALL cover a write: dm_we=1, dm_addr=0x2000, dm_wdata=0xDEADBEEF -> mem_we=1 with those values at grant; dm_rvalid at grant+MEM_LAT with dm_rdata=0.
REQ-031 SHALL cover reset mid-access: reset=1 one cycle after a grant, MEM_LAT=3 -> no rvalid afterwards; all outputs 0; the next request is granted one cycle after reset falls.
REQ-032 SHALL cover the performance counters: with MEM_ARB_PERF_EN defined, fetch blocked 6 cycles -> perf_if_stall=6.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the fetch/data memory port arbiter:
//   - arb_state_e : arbiter state (ARB_IDLE, ARB_WAIT)
//   - arb_owner_e : which port owns the access in flight
//   - default widths, latency and starvation limit
//   - LAT_CNT_W   : width of the latency down-counter (MEM_LAT up to 15)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 4;
    localparam int LAT_CNT_W      = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, data port, memory side and fetch stall status.
//   modport slave  : the arbiter (takes requests and mem_rdata, drives the rest)
//   modport master : the environment (requesters and memory)
// Parameters: ADDR_W, DATA_W.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    // data port
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    // memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // status
    logic              stall_if;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if
    );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// -----------------------------------------------------------------------------
// arb_lat_counter
// Memory latency down-counter. Loads MEM_LAT-1 when a grant is made, counts
// down to zero and holds there; expired_o is high while the count is zero.
// Ports: clk, reset (sync, active high), load_i (grant), expired_o.
// -----------------------------------------------------------------------------
module arb_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic expired_o
);

    localparam logic [LAT_CNT_W-1:0] LOAD_VAL = LAT_CNT_W'(MEM_LAT - 1);

    logic [LAT_CNT_W-1:0] lat_cnt_q;
    logic [LAT_CNT_W-1:0] lat_cnt_d;

    // Next count: reload on grant, otherwise count down and stop at zero.
    always_comb begin
        lat_cnt_d = lat_cnt_q;
        if (load_i) begin
            lat_cnt_d = LOAD_VAL;
        end else if (lat_cnt_q != {LAT_CNT_W{1'b0}}) begin
            lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        end else begin
            lat_cnt_d = lat_cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt_q <= {LAT_CNT_W{1'b0}};
        end else begin
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign expired_o = (lat_cnt_q == {LAT_CNT_W{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, non-pipelined memory between a fetch port and a
// data port, one access outstanding at a time. Grants are combinational in
// IDLE (or in the last WAIT cycle); the owner's rvalid fires MEM_LAT cycles
// after its grant. Data has priority unless fetch has waited through
// STARVE_MAX consecutive data grants.
// Ports: clk, reset (sync, active high), bus (mem_port_arbiter_if.slave).
// Optional feature macro MEM_ARB_PERF_EN adds perf_if_stall / perf_dm_stall,
// 32-bit wrapping counts of cycles with req high and gnt low.
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..15), STARVE_MAX.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_if_stall,
    output logic [31:0] perf_dm_stall
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              we_q, we_d;
    logic [SW-1:0]     starve_q, starve_d;

    logic              expired_s;
    logic              final_s;
    logic              can_grant_s;
    logic              if_win_s;
    logic              dm_win_s;
    logic              grant_s;
    logic              ret_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] ret_data_s;
    logic              if_rvalid_s;
    logic              dm_rvalid_s;

    arb_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk       (clk),
        .reset     (reset),
        .load_i    (grant_s),
        .expired_o (expired_s)
    );

    // The last WAIT cycle behaves as IDLE: the result returns and a new grant
    // may be issued in the same cycle. Reset suppresses every grant.
    assign final_s     = (state_q == ARB_WAIT) && expired_s;
    assign can_grant_s = !reset && ((state_q == ARB_IDLE) || final_s);
    assign if_win_s    = can_grant_s && bus.if_req &&
                         (!bus.dm_req || (starve_q == STARVE_LIM));
    assign dm_win_s    = can_grant_s && bus.dm_req && !if_win_s;
    assign grant_s     = if_win_s || dm_win_s;
    assign mem_we_s    = dm_win_s && bus.dm_we;

    // Memory request mux: winner's address/data, zero when nothing is granted.
    always_comb begin
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        if (if_win_s) begin
            mem_addr_s  = bus.if_addr;
            mem_wdata_s = {DATA_W{1'b0}};
        end else if (dm_win_s) begin
            mem_addr_s  = bus.dm_addr;
            mem_wdata_s = bus.dm_wdata;
        end else begin
            mem_addr_s  = {ADDR_W{1'b0}};
            mem_wdata_s = {DATA_W{1'b0}};
        end
    end

    // Return path: writes complete with zero data; rdata is zero unless valid.
    assign ret_s       = !reset && final_s;
    assign ret_data_s  = we_q ? {DATA_W{1'b0}} : bus.mem_rdata;
    assign if_rvalid_s = ret_s && (owner_q == OWN_IF);
    assign dm_rvalid_s = ret_s && (owner_q == OWN_DM);

    assign bus.if_gnt    = if_win_s;
    assign bus.dm_gnt    = dm_win_s;
    assign bus.if_rvalid = if_rvalid_s;
    assign bus.dm_rvalid = dm_rvalid_s;
    assign bus.if_rdata  = if_rvalid_s ? ret_data_s : {DATA_W{1'b0}};
    assign bus.dm_rdata  = dm_rvalid_s ? ret_data_s : {DATA_W{1'b0}};
    assign bus.mem_en    = grant_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.stall_if  = !reset && bus.if_req && !if_win_s;

    // Next state, owner tracking and starvation count.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        starve_d = starve_q;

        if (grant_s) begin
            state_d = ARB_WAIT;
            owner_d = if_win_s ? OWN_IF : OWN_DM;
            we_d    = mem_we_s;
        end else if (final_s) begin
            state_d = ARB_IDLE;
        end else begin
            state_d = state_q;
        end

        // Counts data grants that bypass a waiting fetch; any gap in if_req
        // or a fetch grant resets the count.
        if (!bus.if_req || if_win_s) begin
            starve_d = {SW{1'b0}};
        end else if (dm_win_s && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Arbiter FSM and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            starve_q <= {SW{1'b0}};
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            starve_q <= starve_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_dm_q, perf_dm_d;

    // Stall cycle counters, wrapping naturally at 2^32.
    always_comb begin
        perf_if_d = perf_if_q + ((bus.if_req && !if_win_s) ? 32'd1 : 32'd0);
        perf_dm_d = perf_dm_q + ((bus.dm_req && !dm_win_s) ? 32'd1 : 32'd0);
    end

    // Stall counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_q <= 32'd0;
            perf_dm_q <= 32'd0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_dm_q <= perf_dm_d;
        end
    end

    assign perf_if_stall = perf_if_q;
    assign perf_dm_stall = perf_dm_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios followed by randomized traffic, every cycle compared with
// a transaction-level reference model (completion-cycle bookkeeping and an
// integer starvation count).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall;
    logic [31:0] perf_dm_stall;
`endif

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MEM_LAT    (LAT),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_stall (perf_if_stall),
        .perf_dm_stall (perf_dm_stall)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int          cyc      = 0;
    bit          m_busy   = 1'b0;
    int          m_done   = 0;
    bit          m_own_if = 1'b0;
    bit          m_we     = 1'b0;
    int          m_starve = 0;
    logic [31:0] m_perf_if = 32'd0;
    logic [31:0] m_perf_dm = 32'd0;
    bit          done_now;

    // expected outputs for the current cycle
    logic          exp_if_gnt, exp_dm_gnt, exp_if_rv, exp_dm_rv;
    logic [DW-1:0] exp_if_rd, exp_dm_rd;
    logic          exp_mem_en, exp_mem_we, exp_stall;
    logic [AW-1:0] exp_mem_addr;
    logic [DW-1:0] exp_mem_wdata;

    logic [9:0] obs_seq;
    int         n_g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_idle();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
    endtask

    // Expected behaviour for this cycle from the current inputs.
    task automatic model_eval();
        exp_if_gnt = 1'b0; exp_dm_gnt = 1'b0;
        exp_if_rv  = 1'b0; exp_dm_rv  = 1'b0;
        exp_if_rd  = '0;   exp_dm_rd  = '0;
        exp_mem_en = 1'b0; exp_mem_we = 1'b0; exp_stall = 1'b0;
        exp_mem_addr = '0; exp_mem_wdata = '0;
        done_now = m_busy && (cyc == m_done);
        if (!reset) begin
            if (done_now) begin
                if (m_own_if) begin
                    exp_if_rv = 1'b1;
                    exp_if_rd = m_we ? '0 : bus.mem_rdata;
                end else begin
                    exp_dm_rv = 1'b1;
                    exp_dm_rd = m_we ? '0 : bus.mem_rdata;
                end
            end
            if (!m_busy || done_now) begin
                if (bus.if_req && (!bus.dm_req || m_starve == SMAX)) begin
                    exp_if_gnt   = 1'b1;
                    exp_mem_en   = 1'b1;
                    exp_mem_addr = bus.if_addr;
                end else if (bus.dm_req) begin
                    exp_dm_gnt    = 1'b1;
                    exp_mem_en    = 1'b1;
                    exp_mem_we    = bus.dm_we;
                    exp_mem_addr  = bus.dm_addr;
                    exp_mem_wdata = bus.dm_wdata;
                end
            end
            exp_stall = bus.if_req && !exp_if_gnt;
        end
    endtask

    // Advance the model past the clock edge.
    task automatic model_commit();
        if (reset) begin
            m_busy    = 1'b0;
            m_starve  = 0;
            m_perf_if = 32'd0;
            m_perf_dm = 32'd0;
        end else begin
            if (bus.if_req && !exp_if_gnt) m_perf_if = m_perf_if + 32'd1;
            if (bus.dm_req && !exp_dm_gnt) m_perf_dm = m_perf_dm + 32'd1;
            if (exp_if_gnt || exp_dm_gnt) begin
                m_busy   = 1'b1;
                m_done   = cyc + LAT;
                m_own_if = exp_if_gnt;
                m_we     = exp_dm_gnt && bus.dm_we;
            end else if (done_now) begin
                m_busy = 1'b0;
            end
            if (!bus.if_req || exp_if_gnt) m_starve = 0;
            else if (exp_dm_gnt && m_starve < SMAX) m_starve++;
        end
        cyc++;
    endtask

    // Drive memory data, settle, compare all outputs with the model.
    task automatic cyc_begin();
        bus.mem_rdata = $urandom();
        #1;
        model_eval();
        chk("if_gnt",    64'(bus.if_gnt),    64'(exp_if_gnt));
        chk("dm_gnt",    64'(bus.dm_gnt),    64'(exp_dm_gnt));
        chk("if_rvalid", 64'(bus.if_rvalid), 64'(exp_if_rv));
        chk("dm_rvalid", 64'(bus.dm_rvalid), 64'(exp_dm_rv));
        chk("if_rdata",  64'(bus.if_rdata),  64'(exp_if_rd));
        chk("dm_rdata",  64'(bus.dm_rdata),  64'(exp_dm_rd));
        chk("mem_en",    64'(bus.mem_en),    64'(exp_mem_en));
        chk("mem_we",    64'(bus.mem_we),    64'(exp_mem_we));
        chk("stall_if",  64'(bus.stall_if),  64'(exp_stall));
        if (exp_mem_en) chk("mem_addr", 64'(bus.mem_addr), 64'(exp_mem_addr));
        if (exp_mem_we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(exp_mem_wdata));
`ifdef MEM_ARB_PERF_EN
        chk("perf_if", 64'(perf_if_stall), 64'(m_perf_if));
        chk("perf_dm", 64'(perf_dm_stall), 64'(m_perf_dm));
`endif
    endtask

    task automatic cyc_end();
        model_commit();
        @(negedge clk);
    endtask

    task automatic step();
        cyc_begin();
        cyc_end();
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        bus.mem_rdata = '0;
        @(negedge clk);

        // reset with both requests high: everything stays at zero
        bus.if_req = 1'b1; bus.dm_req = 1'b1;
        step();
        cyc_begin();
        chk("rst_if_gnt", 64'(bus.if_gnt), 64'd0);
        chk("rst_dm_gnt", 64'(bus.dm_gnt), 64'd0);
        chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
        chk("rst_stall",  64'(bus.stall_if), 64'd0);
        cyc_end();
        drive_idle();
        step();
        reset = 1'b0;
        repeat (2) step();

        // lone fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
        cyc_begin();
        chk("lone_gnt",  64'(bus.if_gnt),   64'd1);
        chk("lone_en",   64'(bus.mem_en),   64'd1);
        chk("lone_addr", 64'(bus.mem_addr), 64'h100);
        cyc_end();
        bus.if_req = 1'b0;
        step();
        cyc_begin();
        chk("lone_rvalid", 64'(bus.if_rvalid), 64'd1);
        chk("lone_rdata",  64'(bus.if_rdata),  64'(bus.mem_rdata));
        cyc_end();
        repeat (2) step();

        // simultaneous requests: data first, fetch at data's rvalid cycle
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0104;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h0000_0300;
        cyc_begin();
        chk("sim_dm_first", 64'(bus.dm_gnt),   64'd1);
        chk("sim_if_wait",  64'(bus.if_gnt),   64'd0);
        chk("sim_stall0",   64'(bus.stall_if), 64'd1);
        cyc_end();
        bus.dm_req = 1'b0;
        cyc_begin();
        chk("sim_stall1", 64'(bus.stall_if), 64'd1);
        cyc_end();
        cyc_begin();
        chk("sim_dm_rv",  64'(bus.dm_rvalid), 64'd1);
        chk("sim_if_gnt", 64'(bus.if_gnt),    64'd1);
        cyc_end();
        drive_idle();
        repeat (3) step();

        // starvation: 4 data grants then 1 fetch grant, repeating
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0500;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h0000_0600;
        obs_seq = '0; n_g = 0;
        for (int i = 0; i < 20; i++) begin
            cyc_begin();
            if (bus.if_gnt || bus.dm_gnt) begin
                if (n_g < 10) obs_seq[n_g] = bus.if_gnt;
                n_g++;
            end
            cyc_end();
        end
        chk("starve_pattern", 64'(obs_seq), 64'b10_0001_0000);
        chk("starve_grants",  64'(n_g),     64'd10);
        drive_idle();
        repeat (3) step();

        // data write
        bus.dm_req = 1'b1; bus.dm_we = 1'b1;
        bus.dm_addr = 32'h0000_2000; bus.dm_wdata = 32'hDEAD_BEEF;
        cyc_begin();
        chk("wr_gnt",   64'(bus.dm_gnt),    64'd1);
        chk("wr_we",    64'(bus.mem_we),    64'd1);
        chk("wr_addr",  64'(bus.mem_addr),  64'h2000);
        chk("wr_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
        cyc_end();
        drive_idle();
        step();
        cyc_begin();
        chk("wr_rvalid", 64'(bus.dm_rvalid), 64'd1);
        chk("wr_rdata",  64'(bus.dm_rdata),  64'd0);
        cyc_end();
        repeat (2) step();

        // reset one cycle after a grant abandons the access
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
        cyc_begin();
        chk("rma_gnt", 64'(bus.if_gnt), 64'd1);
        cyc_end();
        bus.if_req = 1'b0;
        reset = 1'b1;
        cyc_begin();
        chk("rma_en0", 64'(bus.mem_en), 64'd0);
        cyc_end();
        cyc_begin();
        chk("rma_no_rvalid", 64'(bus.if_rvalid), 64'd0);
        cyc_end();
        reset = 1'b0;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h0000_0080;
        cyc_begin();
        chk("rma_regrant", 64'(bus.dm_gnt), 64'd1);
        cyc_end();
        bus.dm_req = 1'b0;
        repeat (3) step();

`ifdef MEM_ARB_PERF_EN
        // fetch blocked for six cycles behind data traffic
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0700;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h0000_0800;
        repeat (6) step();
        cyc_begin();
        chk("perf_if_six", 64'(perf_if_stall), 64'd6);
        cyc_end();
        drive_idle();
        repeat (3) step();
`endif

        // randomized traffic; requesters hold until granted
        for (int i = 0; i < 300; i++) begin
            if (!bus.if_req && ($urandom_range(0, 1) == 1)) begin
                bus.if_req  = 1'b1;
                bus.if_addr = $urandom();
            end
            if (!bus.dm_req && ($urandom_range(0, 1) == 1)) begin
                bus.dm_req   = 1'b1;
                bus.dm_we    = ($urandom_range(0, 2) == 0);
                bus.dm_addr  = $urandom();
                bus.dm_wdata = $urandom();
            end
            reset = ($urandom_range(0, 49) == 0);
            cyc_begin();
            cyc_end();
            if (exp_if_gnt) bus.if_req = 1'b0;
            if (exp_dm_gnt) bus.dm_req = 1'b0;
        end
        reset = 1'b0;
        drive_idle();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
